cache_fill_ctrl: RTL and testbench

//  Initiator side of the 16-bit multi-cycle memory: services cache misses by streaming BLOCK_WORDS

---
 rtl/cache_fill_pkg.sv | 32 +++
 rtl/fill_word_ctr.sv | 45 ++++
 rtl/cache_fill_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// ============================================================================
// Module   : cache_fill_pkg
// Desc     : Shared state encoding and width helpers for the cache fill path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_fill_pkg;

   localparam int c_DWIDTH_DEF      = 16;
   localparam int c_AWIDTH_DEF      = 16;
   localparam int c_BLOCK_WORDS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } fill_state_t;

   // Word index width within a block.
   function automatic int widx_f(input int block_words);
      return $clog2(block_words);
   endfunction

   // Byte offset width within a block (word index plus the byte bit).
   function automatic int off_bits_f(input int block_words);
      return $clog2(block_words) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fill_word_ctr.sv
// ============================================================================
// Module   : fill_word_ctr
// Desc     : Loadable mod-BLOCK_WORDS word index counter with last-step flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_word_ctr
   import cache_fill_pkg::*;
#(
   parameter int   BLOCK_WORDS = c_BLOCK_WORDS_DEF,
   localparam int  c_WIDX      = widx_f(BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [c_WIDX-1:0] i_load_idx,
   input  logic              i_inc,
   output logic [c_WIDX-1:0] o_idx,
   output logic              o_last
);

   logic [c_WIDX-1:0] r_idx;
   logic [c_WIDX-1:0] r_cnt;

   // The index may start mid-block, so the step count is tracked separately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_idx <= i_load_idx;
         r_cnt <= '0;
      end else if (i_inc) begin
         r_idx <= r_idx + 1'b1;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_idx  = r_idx;
   assign o_last = (r_cnt == c_WIDX'(BLOCK_WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
// ============================================================================
// Module   : cache_fill_ctrl
// Desc     : Cache block fill initiator with write-through store forwarding.
// Config   : FILL_CRITICAL_WORD_FIRST_EN - start the fill at the missing word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_ctrl
   import cache_fill_pkg::*;
#(
   parameter int  DWIDTH      = c_DWIDTH_DEF,
   parameter int  AWIDTH      = c_AWIDTH_DEF,
   parameter int  BLOCK_WORDS = c_BLOCK_WORDS_DEF,
   localparam int c_WIDX      = widx_f(BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fill_req,
   input  logic [AWIDTH-1:0] fill_addr,
   output logic              fill_ready,
   input  logic              wr_req,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   output logic              wr_ready,
   output logic              cwr_en,
   output logic [c_WIDX-1:0] cwr_word,
   output logic [DWIDTH-1:0] cwr_data,
   output logic              fill_done,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_enable,
   output logic              mem_wr,
   input  logic [DWIDTH-1:0] mem_rdata,
   input  logic              mem_valid
);

   localparam int                c_OFFW      = off_bits_f(BLOCK_WORDS);
   localparam logic [AWIDTH-1:0] c_OFF_MASK  = AWIDTH'((1 << c_OFFW) - 1);
   localparam logic [AWIDTH-1:0] c_BIT0_MASK = AWIDTH'(1);

   fill_state_t       r_state;
   fill_state_t       w_state_nxt;
   logic [AWIDTH-1:0] r_base;
   logic              r_fill_done;
   logic              w_idle;
   logic              w_accept;
   logic              w_store;
   logic              w_issue;
   logic              w_recv;
   logic              w_issue_last;
   logic              w_recv_last;
   logic [c_WIDX-1:0] w_start_idx;
   logic [c_WIDX-1:0] w_issue_idx;
   logic [c_WIDX-1:0] w_recv_idx;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
   assign w_start_idx = fill_addr[c_WIDX:1];
`else
   assign w_start_idx = '0;
`endif

   // Stores win a simultaneous request; the fill is taken on a later idle cycle.
   assign w_idle   = (r_state == IDLE);
   assign w_store  = w_idle & wr_req;
   assign w_accept = w_idle & fill_req & ~wr_req;
   assign w_recv   = mem_valid & ~w_idle;
   assign w_issue  = (r_state == FILL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_fill_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_fill_done <= w_recv & w_recv_last;
         if (w_accept) begin
            r_base <= fill_addr;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (w_issue_last) begin
               w_state_nxt = (w_recv & w_recv_last) ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (w_recv & w_recv_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ready strobes are forced low while reset is held.
   always_comb begin
      fill_ready = w_idle & rst_n & ~wr_req;
      wr_ready   = w_idle & rst_n;
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (w_store & rst_n) begin
         mem_enable = 1'b1;
         mem_wr     = 1'b1;
         mem_addr   = wr_addr & ~c_BIT0_MASK;
         mem_wdata  = wr_data;
      end else if (w_issue) begin
         mem_enable = 1'b1;
         mem_addr   = (r_base & ~c_OFF_MASK) | AWIDTH'({w_issue_idx, 1'b0});
      end
   end

   assign cwr_en    = w_recv;
   assign cwr_word  = w_recv_idx;
   assign cwr_data  = w_recv ? mem_rdata : '0;
   assign fill_done = r_fill_done;

   fill_word_ctr #(
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_issue_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_load_idx (w_start_idx),
      .i_inc      (w_issue),
      .o_idx      (w_issue_idx),
      .o_last     (w_issue_last)
   );

   fill_word_ctr #(
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_recv_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_load_idx (w_start_idx),
      .i_inc      (w_recv),
      .o_idx      (w_recv_idx),
      .o_last     (w_recv_last)
   );

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
// ============================================================================
// Module   : tb_cache_fill_ctrl
// Desc     : Self-checking bench for cache_fill_ctrl with a latency memory model.
// Config   : FILL_CRITICAL_WORD_FIRST_EN - expected word order follows the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_ctrl;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fill_req;
   logic [AW-1:0] fill_addr;
   logic          fill_ready;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          cwr_en;
   logic [2:0]    cwr_word;
   logic [DW-1:0] cwr_data;
   logic          fill_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_enable;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid;

   always #5 clk = ~clk;

   cache_fill_ctrl #(
      .DWIDTH      (DW),
      .AWIDTH      (AW),
      .BLOCK_WORDS (BW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fill_req   (fill_req),
      .fill_addr  (fill_addr),
      .fill_ready (fill_ready),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .cwr_en     (cwr_en),
      .cwr_word   (cwr_word),
      .cwr_data   (cwr_data),
      .fill_done  (fill_done),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_enable (mem_enable),
      .mem_wr     (mem_wr),
      .mem_rdata  (mem_rdata),
      .mem_valid  (mem_valid)
   );

   typedef struct { int cyc; logic [15:0] a; } rd_t;
   typedef struct { int cyc; int w; logic [15:0] d; } cw_t;
   typedef struct { int due; logic [15:0] d; } rsp_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          lat   = 4;
   logic [15:0] mem [logic [15:0]];
   rd_t         rd_q[$];
   cw_t         cw_q[$];
   rsp_t        rsp_q[$];
   int          done_q[$];
   int          st_q[$];
   int          acc_q[$];
   logic        s_wr_ready;

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rd_q.delete(); cw_q.delete(); done_q.delete(); st_q.delete(); acc_q.delete();
   endtask

   // One clock: sample at the falling edge, then move memory responses after the rising edge.
   task automatic tick();
      rd_t  rd;
      cw_t  cw;
      rsp_t rs;
      bit   acc_f, st_f;
      @(negedge clk);
      s_wr_ready = wr_ready;
      acc_f = fill_req && fill_ready;
      st_f  = wr_req && wr_ready;
      if (mem_enable && !mem_wr) begin
         rd.cyc = cyc; rd.a = mem_addr; rd_q.push_back(rd);
         rs.due = cyc + lat; rs.d = mem_rd(mem_addr); rsp_q.push_back(rs);
      end
      if (mem_enable && mem_wr) begin
         st_q.push_back(cyc);
         mem[mem_addr] = mem_wdata;
      end
      if (cwr_en) begin
         cw.cyc = cyc; cw.w = int'(cwr_word); cw.d = cwr_data; cw_q.push_back(cw);
      end
      if (fill_done) done_q.push_back(cyc);
      if (acc_f) acc_q.push_back(cyc);
      @(posedge clk);
      #1;
      cyc++;
      if (acc_f) fill_req = 1'b0;
      if (st_f) wr_req = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         rs = rsp_q.pop_front();
         mem_valid = 1'b1;
         mem_rdata = rs.d;
      end
   endtask

   task automatic start_fill(input logic [15:0] addr, input int l, output int a);
      clear_logs();
      lat       = l;
      fill_addr = addr;
      fill_req  = 1'b1;
      for (int i = 0; i < 20 && acc_q.size() == 0; i++) tick();
      chk("accept_seen", 32'(acc_q.size()), 1);
      a = (acc_q.size() > 0) ? acc_q[0] : cyc;
      fill_req = 1'b0;
   endtask

   // Expected block traffic derived from the block base, start word and memory latency.
   task automatic finish_fill(input string tag, input logic [15:0] addr, input int l, input int a);
      int          start, n, w;
      logic [15:0] base;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
      start = int'(addr[3:1]);
`else
      start = 0;
`endif
      base = addr & 16'hFFF0;
      while (cyc < a + l + 12) tick();
      n = 0;
      foreach (rd_q[i]) begin
         if (rd_q[i].cyc > a) begin
            if (n < BW) begin
               chk({tag, "_rd_cyc"}, 32'(rd_q[i].cyc), 32'(a + 1 + n));
               chk({tag, "_rd_addr"}, 32'(rd_q[i].a), 32'(base + 16'(2 * ((start + n) % BW))));
            end
            n++;
         end
      end
      chk({tag, "_rd_count"}, 32'(n), BW);
      n = 0;
      foreach (cw_q[i]) begin
         if (cw_q[i].cyc > a) begin
            if (n < BW) begin
               w = (start + n) % BW;
               chk({tag, "_cw_cyc"}, 32'(cw_q[i].cyc), 32'(a + 1 + n + l));
               chk({tag, "_cw_word"}, 32'(cw_q[i].w), 32'(w));
               chk({tag, "_cw_data"}, 32'(cw_q[i].d), 32'(mem_rd(base + 16'(2 * w))));
            end
            n++;
         end
      end
      chk({tag, "_cw_count"}, 32'(n), BW);
      chk({tag, "_done_count"}, 32'(done_q.size()), 1);
      if (done_q.size() > 0) chk({tag, "_done_cyc"}, 32'(done_q[0]), 32'(a + 9 + l));
   endtask

   initial begin
      int          a, n, l;
      logic [15:0] addr;
      rst_n = 1'b0; fill_req = 1'b0; fill_addr = '0; wr_req = 1'b0;
      wr_addr = '0; wr_data = '0; mem_valid = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fill_ready", 32'(fill_ready), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_mem_enable", 32'(mem_enable), 0);
      chk("rst_cwr_en", 32'(cwr_en), 0);
      chk("rst_fill_done", 32'(fill_done), 0);
      rst_n = 1'b1;
      #1;
      chk("idle_fill_ready", 32'(fill_ready), 1);
      chk("idle_wr_ready", 32'(wr_ready), 1);
      chk("idle_mem_enable", 32'(mem_enable), 0);

      // Basic block fill at the example address.
      start_fill(16'h1236, 4, a);
      finish_fill("t1", 16'h1236, 4, a);

      // Write-through store, then a fill that returns the stored word.
      clear_logs();
      wr_addr = 16'h0040; wr_data = 16'hBEEF; wr_req = 1'b1;
      #1;
      chk("t2_mem_enable", 32'(mem_enable), 1);
      chk("t2_mem_wr", 32'(mem_wr), 1);
      chk("t2_mem_addr", 32'(mem_addr), 32'h0040);
      chk("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      tick();
      chk("t2_store_count", 32'(st_q.size()), 1);
      start_fill(16'h0040, 4, a);
      finish_fill("t2", 16'h0040, 4, a);
      if (cw_q.size() > 0) chk("t2_word0", 32'(cw_q[0].d), 32'hBEEF);

      // Simultaneous store and fill: store first, fill on the next cycle.
      clear_logs();
      wr_addr = 16'h0101; wr_data = 16'h1357; wr_req = 1'b1;
      fill_addr = 16'h2000; fill_req = 1'b1;
      #1;
      chk("t3_fill_ready", 32'(fill_ready), 0);
      chk("t3_store_en", 32'(mem_enable & mem_wr), 1);
      chk("t3_store_addr", 32'(mem_addr), 32'h0100);
      tick();
      chk("t3_no_accept_yet", 32'(acc_q.size()), 0);
      tick();
      chk("t3_accept_seen", 32'(acc_q.size()), 1);
      if (acc_q.size() > 0 && st_q.size() > 0) chk("t3_accept_cyc", 32'(acc_q[0]), 32'(st_q[0] + 1));
      a = (acc_q.size() > 0) ? acc_q[0] : cyc;
      finish_fill("t3", 16'h2000, 4, a);

      // Store held during a fill stalls until the controller is idle again.
      start_fill(16'h4448, 4, a);
      tick();
      wr_addr = 16'h8000; wr_data = 16'hCAFE; wr_req = 1'b1;
      #1;
      chk("t4_fill_ready_busy", 32'(fill_ready), 0);
      tick();
      chk("t4_wr_ready_busy", 32'(s_wr_ready), 0);
      for (int i = 0; i < 30 && st_q.size() == 0; i++) tick();
      chk("t4_store_count", 32'(st_q.size()), 1);
      if (st_q.size() > 0) chk("t4_store_cyc", 32'(st_q[0]), 32'(a + 13));
      finish_fill("t4", 16'h4448, 4, a);

      // Reset in fill cycle 5 aborts; stale returns afterwards are ignored.
      start_fill(16'h3456, 4, a);
      while (cyc < a + 5) tick();
      rst_n = 1'b0;
      #1;
      chk("t5_cwr_en", 32'(cwr_en), 0);
      chk("t5_mem_enable", 32'(mem_enable), 0);
      chk("t5_fill_ready", 32'(fill_ready), 0);
      chk("t5_wr_ready", 32'(wr_ready), 0);
      chk("t5_mem_addr", 32'(mem_addr), 0);
      chk("t5_fill_done", 32'(fill_done), 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("t5_ready_after", 32'(fill_ready), 1);
      repeat (8) tick();
      n = 0;
      foreach (cw_q[i]) if (cw_q[i].cyc >= a + 5) n++;
      chk("t5_stale_cwr", 32'(n), 0);
      chk("t5_no_done", 32'(done_q.size()), 0);
      chk("t5_reads_before_reset", 32'(rd_q.size()), 4);

      // Mid-block miss address; word order depends on the critical-word-first build.
      start_fill(16'h123A, 4, a);
      finish_fill("t6", 16'h123A, 4, a);

      // Randomized fills with varied memory latency and optional prior stores.
      for (int k = 0; k < 8; k++) begin
         l    = int'($urandom_range(1, 6));
         addr = 16'($urandom()) & 16'hFFFE;
         if ($urandom_range(0, 1) == 1) begin
            clear_logs();
            wr_addr = (addr & 16'hFFF0) | 16'(2 * $urandom_range(0, 7));
            wr_data = 16'($urandom());
            wr_req  = 1'b1;
            tick();
            chk("rnd_store", 32'(st_q.size()), 1);
         end
         start_fill(addr, l, a);
         finish_fill("rnd", addr, l, a);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
